ddr3_app_responder: RTL and testbench
=====================================

# ddr3_app_responder

Synthesizable responder for the Gowin DDR3 user (`app_*`) interface, backed by on-chip block RAM. It sits where the DDR3 IP normally sits, on the far side of the cache-to-DDR3 bridge. It accepts write and read burst commands and returns read data with fixed latency, so the bridge and the cache can be brought up and regression-tested on-board and in simulation without the DDR3 PHY.

## Interface
- `ADDR_W`, 27: width of `app_addr`, in 16-bit DDR words.
- `DATA_W`, 128: beat width; one beat is one BL8 on a x16 device.
- `DEPTH_LOG2`, 10: log2 of BRAM depth in beats (1024 beats = 16 KiB).
- `CALIB_CYCLES`, 64: cycles from reset release until `init_calib_complete` rises.
- `RD_LATENCY`, 4: cycles from read command acceptance to the first read beat; minimum 2.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `app_burst_number` in 6: number of beats minus one.
- `app_cmd_ready` out 1: the responder can accept a command.
- `app_cmd` in 3: 3'd0 is write, 3'd1 is read.
- `app_cmd_en` in 1: command valid.
- `app_addr` in ADDR_W: start address, in 16-bit words.
- `app_wdata_ready` out 1: the responder can accept a write beat.
- `app_wdata` in DATA_W: write beat.
- `app_wdata_en` in 1: write beat valid.
- `app_wdata_end` in 1: marks the last write beat.
- `app_wdata_mask` in DATA_W/8: 1 means the byte is NOT written.
- `app_rdata` out DATA_W: read beat.
- `app_rdata_valid` out 1: read beat valid.
- `app_rdata_end` out 1: marks the last read beat.
- `init_calib_complete` out 1: models end of calibration.
- `err_proto` out 1: sticky protocol-error flag; cleared only by reset.

## Operation
- States:
  - CALIB: counts up to CALIB_CYCLES, then moves to IDLE.
  - IDLE: `app_cmd_ready` = `app_wdata_ready` = 1.
  - WRITE: `app_cmd_ready` = 0, `app_wdata_ready` = 1.
  - READ: `app_cmd_ready` = 0, `app_wdata_ready` = 0.
- Command acceptance: a command is accepted when `app_cmd_en && app_cmd_ready`. At acceptance the responder latches `app_addr`, `app_burst_number` and `app_cmd`.
- Beat index: the memory index is `addr[DEPTH_LOG2+2:3]`. It increments by 1 per beat and wraps modulo 2^DEPTH_LOG2. `addr[2:0]` is ignored; if it is nonzero, `err_proto` is set.
- Write:
  - A beat is accepted when `app_wdata_en && app_wdata_ready`.
  - A beat presented in the same cycle as the write command is beat 0.
  - Each accepted beat writes the unmasked bytes at the current index.
  - After `app_burst_number`+1 beats the FSM returns to IDLE.
  - If `app_wdata_end` disagrees with the beat count (early or missing), `err_proto` is set. The burst still ends on the count.
- Write beat while in IDLE without a write command: the beat is dropped and `err_proto` is set.
- Read:
  - After acceptance the FSM waits RD_LATENCY cycles.
  - It then emits `app_burst_number`+1 consecutive beats with `app_rdata_valid`=1.
  - `app_rdata_end`=1 only on the last beat.
  - Read has no backpressure.
- `app_cmd_en` with any `app_cmd` other than 0 or 1: the command is ignored, the FSM stays in IDLE, and `err_proto` is set.
- Reset mid-burst: all outputs and the FSM return to reset values immediately. BRAM contents are not cleared and are undefined to the bench.

## Timing
- Reset values:
  - `app_cmd_ready`, `app_wdata_ready`, `app_rdata_valid`, `app_rdata_end`, `init_calib_complete`, `err_proto`: 0.
  - `app_rdata`: 0.
  - FSM: CALIB.
- `init_calib_complete` rises in the cycle where the counter reaches CALIB_CYCLES after `rstn` deasserts. `app_cmd_ready` rises in the same cycle.
- Read latency: command accepted at edge T gives the first `app_rdata_valid` at T+RD_LATENCY and the last at T+RD_LATENCY+burst_number.
- `app_cmd_ready` returns to 1 in the cycle after the last read beat.
- Write: `app_cmd_ready` returns to 1 in the cycle after the last write beat is accepted.
- Back-to-back write then read: a read of the same index issued immediately after the write returns the new data. The BRAM runs in read-after-write / no-change mode with the write committed before the read.
- Maximum throughput: one write beat per cycle. Read beats are contiguous.

## Structure
- Shared package/header `ddr3_app_pkg`: command codes `CMD_WR`=3'd0 and `CMD_RD`=3'd1, FSM state encodings, and default widths. The bridge imports the same command codes.
- Sub-module `sdp_bram_be`: simple-dual-port RAM, DEPTH_LOG2 × DATA_W, with per-byte write enable (the inverse of the mask) and a registered read port. The RD_LATENCY pipeline is a shift register in the parent that aligns valid/end with the BRAM output.

## Test plan
- Calibration and ready:
  - Stimulus: release reset, keep all inputs idle.
  - Required: `init_calib_complete` and `app_cmd_ready` rise exactly 64 cycles after `rstn` rises; `err_proto` stays 0.
- Full write then read:
  - Stimulus: write at addr 0x40, burst_number 3, data 0x1..0x4, mask 0; then read at addr 0x40, burst_number 3.
  - Required: 4 valid beats 0x1..0x4 starting 4 cycles after read acceptance; `app_rdata_end` only on 0x4.
- Byte masking:
  - Stimulus: write all-ones at addr 0; write 0 at addr 0 with mask 16'h00FF; read addr 0.
  - Required: data {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}.
- Index wrap:
  - Stimulus: write burst_number 1 at addr (1023<<3).
  - Required: the second beat lands at index 0; a read of addr 0 returns it.
- Protocol errors:
  - Stimulus: `app_cmd`=3'd2 in one case; early `app_wdata_end` on beat 1 of 4 in another.
  - Required: `err_proto` sets and stays set; the FSM returns to IDLE after 4 beats.
- Reset mid-read:
  - Stimulus: pulse `rstn` low during beat 2 of 8.
  - Required: `app_rdata_valid`=0 asynchronously; recalibration takes 64 cycles.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app_* interface: command codes, responder
// FSM states and default widths. The bridge imports the same command codes.
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    localparam int DEF_ADDR_W       = 27;
    localparam int DEF_DATA_W       = 128;
    localparam int DEF_DEPTH_LOG2   = 10;
    localparam int DEF_CALIB_CYCLES = 64;
    localparam int DEF_RD_LATENCY   = 4;

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    function automatic logic cmd_known(input logic [2:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/ddr3_app_responder_if.sv
// User-side (app_*) bus of the Gowin DDR3 IP; the bridge is the master and
// the memory model (or the real IP) is the slave.
interface ddr3_app_responder_if
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [5:0]          app_burst_number;
    logic                app_cmd_ready;
    logic [2:0]          app_cmd;
    logic                app_cmd_en;
    logic [ADDR_W-1:0]   app_addr;
    logic                app_wdata_ready;
    logic [DATA_W-1:0]   app_wdata;
    logic                app_wdata_en;
    logic                app_wdata_end;
    logic [DATA_W/8-1:0] app_wdata_mask;
    logic [DATA_W-1:0]   app_rdata;
    logic                app_rdata_valid;
    logic                app_rdata_end;
    logic                init_calib_complete;
    logic                err_proto;

    modport master (
        output app_burst_number, app_cmd, app_cmd_en, app_addr,
               app_wdata, app_wdata_en, app_wdata_end, app_wdata_mask,
        input  app_cmd_ready, app_wdata_ready, app_rdata, app_rdata_valid,
               app_rdata_end, init_calib_complete, err_proto
    );

    modport slave (
        input  app_burst_number, app_cmd, app_cmd_en, app_addr,
               app_wdata, app_wdata_en, app_wdata_end, app_wdata_mask,
        output app_cmd_ready, app_wdata_ready, app_rdata, app_rdata_valid,
               app_rdata_end, init_calib_complete, err_proto
    );

endinterface

// File: rtl/sdp_bram_be.sv
// Simple-dual-port block RAM with per-byte write enables and a registered
// read port (one cycle from address to data).
module sdp_bram_be #(
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ddr3_app_responder.sv
// Block-RAM-backed stand-in for the Gowin DDR3 IP user interface: accepts
// write/read bursts and returns read beats at a fixed latency.
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int CALIB_CYCLES = DEF_CALIB_CYCLES,
    parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
    input logic                 clk,
    input logic                 rstn,
    ddr3_app_responder_if.slave app
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(RD_LATENCY + 66);
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam logic [CNT_W-1:0] ISSUE_FIRST = CNT_W'(RD_LATENCY - 2);
    localparam logic [CAL_W-1:0] CAL_LAST    = CAL_W'(CALIB_CYCLES - 1);

    state_e                state;
    logic [CAL_W-1:0]      calib_cnt;
    logic [CNT_W-1:0]      cnt;
    logic [5:0]            len;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;

    logic cmd_ready;
    logic wdata_ready;
    logic calib_done;
    logic err;

    logic                  cmd_fire;
    logic                  beat_fire;
    logic                  wr_cmd;
    logic                  rd_cmd;
    logic                  bad_cmd;
    logic                  misalign;
    logic [DEPTH_LOG2-1:0] cmd_idx;
    logic [CNT_W-1:0]      len_ext;
    logic [CNT_W-1:0]      rd_beat;
    logic                  rd_issue;
    logic                  rd_last;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [BE_W-1:0]       ram_be;
    logic [DATA_W-1:0]     ram_q;

    logic              vld_p0;
    logic              end_p0;
    logic              vld_p1;
    logic              end_p1;
    logic [DATA_W-1:0] data_p1;

    logic unused_addr_hi;

    assign cmd_fire  = app.app_cmd_en && cmd_ready;
    assign beat_fire = app.app_wdata_en && wdata_ready;
    assign wr_cmd    = cmd_fire && (app.app_cmd == CMD_WR);
    assign rd_cmd    = cmd_fire && (app.app_cmd == CMD_RD);
    assign bad_cmd   = cmd_fire && !cmd_known(app.app_cmd);
    assign misalign  = (wr_cmd || rd_cmd) && (app.app_addr[2:0] != 3'd0);
    assign cmd_idx   = app.app_addr[DEPTH_LOG2+2:3];
    assign len_ext   = CNT_W'(len);

    assign unused_addr_hi = ^app.app_addr[ADDR_W-1:DEPTH_LOG2+3];

    // In READ, cnt counts cycles since acceptance; reads are issued two cycles
    // ahead of the output so the RAM register and the output register line up.
    assign rd_beat  = cnt - ISSUE_FIRST;
    assign rd_issue = (state == ST_READ) && (cnt >= ISSUE_FIRST) && (rd_beat <= len_ext);
    assign rd_last  = rd_issue && (rd_beat == len_ext);

    assign ram_we    = beat_fire && (wr_cmd || (state == ST_WRITE));
    assign ram_waddr = (state == ST_WRITE) ? wr_idx : cmd_idx;
    assign ram_be    = ~app.app_wdata_mask;

    sdp_bram_be #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_be   (ram_be),
        .wr_data (app.app_wdata),
        .rd_en   (rd_issue),
        .rd_addr (rd_idx),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_CALIB;
            calib_cnt   <= '0;
            cnt         <= '0;
            len         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            cmd_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            calib_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_CALIB: begin
                    if (calib_cnt == CAL_LAST) begin
                        state       <= ST_IDLE;
                        calib_done  <= 1'b1;
                        cmd_ready   <= 1'b1;
                        wdata_ready <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A stray beat without a write command is dropped.
                    if (bad_cmd || misalign || (beat_fire && !wr_cmd)) begin
                        err <= 1'b1;
                    end
                    if (wr_cmd) begin
                        len <= app.app_burst_number;
                        if (beat_fire) begin
                            if (app.app_wdata_end != (app.app_burst_number == 6'd0)) begin
                                err <= 1'b1;
                            end
                            wr_idx <= cmd_idx + 1'b1;
                            cnt    <= CNT_W'(1);
                            if (app.app_burst_number != 6'd0) begin
                                state     <= ST_WRITE;
                                cmd_ready <= 1'b0;
                            end
                        end else begin
                            wr_idx    <= cmd_idx;
                            cnt       <= '0;
                            state     <= ST_WRITE;
                            cmd_ready <= 1'b0;
                        end
                    end else if (rd_cmd) begin
                        len         <= app.app_burst_number;
                        rd_idx      <= cmd_idx;
                        cnt         <= '0;
                        state       <= ST_READ;
                        cmd_ready   <= 1'b0;
                        wdata_ready <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (beat_fire) begin
                        if (app.app_wdata_end != (cnt == len_ext)) begin
                            err <= 1'b1;
                        end
                        wr_idx <= wr_idx + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == len_ext) begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    cnt <= cnt + 1'b1;
                    if (rd_issue) begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                    // Leave one cycle after the last beat reaches the output.
                    if (cnt == ISSUE_FIRST + len_ext + CNT_W'(2)) begin
                        state       <= ST_IDLE;
                        cmd_ready   <= 1'b1;
                        wdata_ready <= 1'b1;
                    end
                end
                default: state <= ST_CALIB;
            endcase
        end
    end

    // p0: RAM output register stage; p1: output register stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0  <= 1'b0;
            end_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            end_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p0 <= rd_issue;
            end_p0 <= rd_last;
            vld_p1 <= vld_p0;
            end_p1 <= end_p0;
            if (vld_p0) begin
                data_p1 <= ram_q;
            end
        end
    end

    assign app.app_cmd_ready       = cmd_ready;
    assign app.app_wdata_ready     = wdata_ready;
    assign app.app_rdata           = data_p1;
    assign app.app_rdata_valid     = vld_p1;
    assign app.app_rdata_end       = end_p1;
    assign app.init_calib_complete = calib_done;
    assign app.err_proto           = err;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Bench for ddr3_app_responder: a transaction-level memory model predicts
// every output each cycle, and directed bursts pin latencies and data.
module tb_ddr3_app_responder;
    import ddr3_app_pkg::*;

    localparam int L   = 4;
    localparam int CAL = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    ddr3_app_responder_if #(.ADDR_W(27), .DATA_W(128)) app();

    ddr3_app_responder #(
        .ADDR_W       (27),
        .DATA_W       (128),
        .DEPTH_LOG2   (10),
        .CALIB_CYCLES (CAL),
        .RD_LATENCY   (L)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .app  (app)
    );

    int errors = 0;
    int checks = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level model: ready is derived from "still calibrating",
    // "write beats outstanding" and "read busy until cycle N".
    int           cyc = 0;
    bit           m_cal = 1'b0;
    int           m_edges = 0;
    int           m_wr_left = 0;
    logic [9:0]   m_wr_idx = '0;
    int           m_free_at = 0;
    bit           m_err = 1'b0;
    bit           m_ready = 1'b0;
    bit           m_wready = 1'b0;
    logic [127:0] m_mem [1024];
    logic [127:0] exp_data [int];
    bit           exp_end [int];
    bit           cmd_ok, wd_ok;
    logic [9:0]   m_idx;
    int           m_bn;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cal = 1'b0;
            m_edges = 0;
            m_wr_left = 0;
            m_free_at = 0;
            m_err = 1'b0;
            m_ready = 1'b0;
            m_wready = 1'b0;
            exp_data.delete();
            exp_end.delete();
        end else begin
            cmd_ok = m_ready;
            wd_ok  = m_wready;
            cyc++;
            if (!m_cal) begin
                m_edges++;
                if (m_edges == CAL) m_cal = 1'b1;
            end else begin
                if (app.app_cmd_en && cmd_ok) begin
                    m_idx = app.app_addr[12:3];
                    m_bn  = int'(app.app_burst_number);
                    if (app.app_cmd == CMD_WR) begin
                        m_wr_left = m_bn + 1;
                        m_wr_idx  = m_idx;
                    end else if (app.app_cmd == CMD_RD) begin
                        for (int k = 0; k <= m_bn; k++) begin
                            exp_data[cyc + L + k] = m_mem[m_idx + 10'(k)];
                            exp_end[cyc + L + k]  = (k == m_bn);
                        end
                        m_free_at = cyc + L + m_bn + 1;
                    end else begin
                        m_err = 1'b1;
                    end
                    if (app.app_cmd <= CMD_RD && app.app_addr[2:0] != 3'd0) m_err = 1'b1;
                end
                if (app.app_wdata_en && wd_ok) begin
                    if (m_wr_left == 0) begin
                        m_err = 1'b1;
                    end else begin
                        for (int b = 0; b < 16; b++)
                            if (!app.app_wdata_mask[b]) m_mem[m_wr_idx][b*8 +: 8] = app.app_wdata[b*8 +: 8];
                        m_wr_idx = m_wr_idx + 10'd1;
                        m_wr_left--;
                        if (app.app_wdata_end != (m_wr_left == 0)) m_err = 1'b1;
                    end
                end
            end
            m_ready  = m_cal && (m_wr_left == 0) && (cyc >= m_free_at);
            m_wready = m_cal && (cyc >= m_free_at);
        end
    end

    always @(negedge clk) begin
        check1("cmd_ready", app.app_cmd_ready, m_ready);
        check1("wdata_ready", app.app_wdata_ready, m_wready);
        check1("init_calib_complete", app.init_calib_complete, m_cal);
        check1("err_proto", app.err_proto, m_err);
        check1("rdata_valid", app.app_rdata_valid, exp_data.exists(cyc) != 0);
        if (exp_data.exists(cyc) != 0) begin
            check128("rdata", app.app_rdata, exp_data[cyc]);
            check1("rdata_end", app.app_rdata_end, exp_end[cyc]);
        end else begin
            check1("rdata_end_idle", app.app_rdata_end, 1'b0);
        end
    end

    logic [127:0] wbuf [8];
    logic [127:0] got [$];
    bit           got_end [$];
    int           lat;

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (m_ready) return;
            @(posedge clk); #1;
        end
        check1("wait_ready_timeout", m_ready, 1'b1);
    endtask

    task automatic issue(input logic [2:0] c, input logic [26:0] a, input logic [5:0] bn);
        wait_ready();
        app.app_cmd_en = 1'b1;
        app.app_cmd = c;
        app.app_addr = a;
        app.app_burst_number = bn;
        @(posedge clk); #1;
        app.app_cmd_en = 1'b0;
    endtask

    task automatic write_burst(input logic [26:0] a, input int n, input logic [15:0] mask, input int end_at);
        wait_ready();
        app.app_cmd_en = 1'b1;
        app.app_cmd = CMD_WR;
        app.app_addr = a;
        app.app_burst_number = 6'(n - 1);
        app.app_wdata_en = 1'b1;
        app.app_wdata = wbuf[0];
        app.app_wdata_mask = mask;
        app.app_wdata_end = (end_at == 0);
        @(posedge clk); #1;
        app.app_cmd_en = 1'b0;
        for (int i = 1; i < n; i++) begin
            app.app_wdata = wbuf[i];
            app.app_wdata_end = (i == end_at);
            @(posedge clk); #1;
        end
        app.app_wdata_en = 1'b0;
        app.app_wdata_end = 1'b0;
        app.app_wdata_mask = '0;
    endtask

    task automatic read_collect(input logic [26:0] a, input logic [5:0] bn);
        issue(CMD_RD, a, bn);
        got.delete();
        got_end.delete();
        lat = -1;
        for (int k = 1; k <= L + int'(bn) + 10; k++) begin
            @(posedge clk); #1;
            if (app.app_rdata_valid) begin
                if (lat < 0) lat = k;
                got.push_back(app.app_rdata);
                got_end.push_back(app.app_rdata_end);
            end
        end
    endtask

    task automatic calib_check(input string tag);
        for (int i = 1; i <= CAL; i++) begin
            @(posedge clk); #1;
            if (i == CAL - 1) begin
                check1({tag, "_calib_before"}, app.init_calib_complete, 1'b0);
                check1({tag, "_ready_before"}, app.app_cmd_ready, 1'b0);
            end
        end
        check1({tag, "_calib_at_64"}, app.init_calib_complete, 1'b1);
        check1({tag, "_ready_at_64"}, app.app_cmd_ready, 1'b1);
        check1({tag, "_err_clear"}, app.err_proto, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        app.app_cmd_en = 1'b0;
        app.app_cmd = '0;
        app.app_addr = '0;
        app.app_burst_number = '0;
        app.app_wdata = '0;
        app.app_wdata_en = 1'b0;
        app.app_wdata_end = 1'b0;
        app.app_wdata_mask = '0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_cmd_ready", app.app_cmd_ready, 1'b0);
        check1("rst_wdata_ready", app.app_wdata_ready, 1'b0);
        check1("rst_rdata_valid", app.app_rdata_valid, 1'b0);
        check1("rst_calib", app.init_calib_complete, 1'b0);
        check1("rst_err", app.err_proto, 1'b0);
        check128("rst_rdata", app.app_rdata, 128'h0);
        rstn = 1'b1;
        calib_check("cal1");

        // Four-beat write then immediate read of the same beats
        for (int i = 0; i < 4; i++) wbuf[i] = 128'(i + 1);
        write_burst(27'h40, 4, 16'h0, 3);
        read_collect(27'h40, 6'd3);
        check_int("wr_rd_latency", lat, 4);
        check_int("wr_rd_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                check128("wr_rd_data", got[i], 128'(i + 1));
                check1("wr_rd_end", got_end[i], i == 3);
            end
        end

        // Byte mask: low eight bytes keep the all-ones pattern
        wbuf[0] = '1;
        write_burst(27'h0, 1, 16'h0, 0);
        wbuf[0] = '0;
        write_burst(27'h0, 1, 16'h00FF, 0);
        read_collect(27'h0, 6'd0);
        check_int("mask_count", got.size(), 1);
        if (got.size() > 0) check128("mask_data", got[0], {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

        // Index wrap from 1023 to 0
        wbuf[0] = 128'hA5A5;
        wbuf[1] = 128'h5A5A_0001;
        write_burst(27'h1FF8, 2, 16'h0, 1);
        read_collect(27'h0, 6'd0);
        check_int("wrap_count0", got.size(), 1);
        if (got.size() > 0) check128("wrap_idx0", got[0], 128'h5A5A_0001);
        read_collect(27'h1FF8, 6'd1);
        check_int("wrap_count", got.size(), 2);
        if (got.size() > 1) begin
            check128("wrap_beat0", got[0], 128'hA5A5);
            check128("wrap_beat1", got[1], 128'h5A5A_0001);
            check1("wrap_end", got_end[1], 1'b1);
        end

        // Unknown command is ignored and latches the error
        check1("err_before_badcmd", app.err_proto, 1'b0);
        issue(3'd2, 27'h0, 6'd0);
        check1("err_after_badcmd", app.err_proto, 1'b1);
        check1("ready_after_badcmd", app.app_cmd_ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check1("err_sticky", app.err_proto, 1'b1);

        // Reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = 128'h100 + 128'(i);
        write_burst(27'h100, 8, 16'h0, 7);
        issue(CMD_RD, 27'h100, 6'd7);
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(posedge clk); #1;
            if (app.app_rdata_valid) seen++;
        end
        check_int("midread_beats_seen", seen, 2);
        rstn = 1'b0;
        #1;
        check1("midread_valid_async", app.app_rdata_valid, 1'b0);
        check1("midread_ready_async", app.app_cmd_ready, 1'b0);
        check1("midread_calib_async", app.init_calib_complete, 1'b0);
        check1("midread_err_async", app.err_proto, 1'b0);
        check128("midread_rdata_async", app.app_rdata, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        calib_check("cal2");

        // Early wdata_end on beat 1 of 4: error, burst still ends on count
        for (int i = 0; i < 4; i++) wbuf[i] = 128'h11 * 128'(i + 1);
        write_burst(27'h200, 4, 16'h0, 1);
        check1("early_end_err", app.err_proto, 1'b1);
        check1("early_end_ready", app.app_cmd_ready, 1'b1);
        read_collect(27'h200, 6'd3);
        check_int("early_end_count", got.size(), 4);
        if (got.size() > 3) begin
            check128("early_end_beat0", got[0], 128'h11);
            check128("early_end_beat3", got[3], 128'h44);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
